load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU in the RV32I core.
- Consumes the ALU result as the effective address and rs2 data as store data.
- Runs a valid/grant/rvalid handshake to the data memory, then returns sign- or zero-extended load data to writeback.
- Stalls the pipeline while an access is outstanding.

---
 rtl/core_pkg.sv | 16 +
 rtl/lsu_align.sv | 67 ++++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: funct3 access encodings and LSU state type.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: access checks, store lane placement and
// load extraction with sign/zero extension. Purely combinational.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_we,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign half_v = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    o_wstrb      = 4'b0000;
    o_wdata      = 32'h0;
    o_load_data  = 32'h0;

    case (i_funct3)
      F3_B, F3_BU: o_misaligned = 1'b0;
      F3_H, F3_HU: o_misaligned = i_addr_lo[0];
      F3_W:        o_misaligned = (i_addr_lo != 2'b00);
      default:     o_illegal    = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (i_we && (i_funct3 == F3_BU || i_funct3 == F3_HU)) o_illegal = 1'b1;

    case (i_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      F3_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
      end
      default: o_wstrb = 4'b0000;
    endcase
    if (!i_we) o_wstrb = 4'b0000;

    case (i_funct3)
      F3_B:    o_load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    o_load_data = {{16{half_v[15]}}, half_v};
      F3_W:    o_load_data = i_rdata;
      F3_BU:   o_load_data = {24'h0, byte_v};
      F3_HU:   o_load_data = {16'h0, half_v};
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one outstanding dmem access with timeout abort.
// state | meaning
// IDLE  | no access in flight, new accesses checked and accepted here
// REQ   | o_dmem_req held with stable address/data until grant
// WAIT  | load granted, waiting for rvalid
module load_store_unit
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_fault,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          done_q;
  logic          fault_q;
  logic          skip_q;
  logic [31:0]   load_data_q;

  logic          in_idle;
  logic          start;
  logic          chk_ok;
  logic          timed_out;
  logic          misaligned;
  logic          illegal;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;
  logic [31:0]   al_load;

  // Checks use the incoming instruction in IDLE; extraction uses the latched
  // access while waiting, so one aligner serves both.
  assign in_idle = (state_q == IDLE);

  lsu_align u_align (
    .i_funct3     (in_idle ? i_funct3 : f3_q),
    .i_addr_lo    (in_idle ? i_addr[1:0] : addr_q[1:0]),
    .i_we         (in_idle ? i_mem_write : we_q),
    .i_store_data (i_store_data),
    .i_rdata      (i_dmem_rdata),
    .o_misaligned (misaligned),
    .o_illegal    (illegal),
    .o_wstrb      (al_wstrb),
    .o_wdata      (al_wdata),
    .o_load_data  (al_load)
  );

  // skip_q blocks re-acceptance of the instruction still held during its own
  // done/timeout cycle.
  assign start     = i_valid & (i_mem_read ^ i_mem_write) & ~skip_q;
  assign chk_ok    = ~misaligned & ~illegal;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  assign o_busy       = !in_idle || (start && chk_ok);
  assign o_done       = done_q;
  assign o_fault      = fault_q;
  assign o_load_data  = load_data_q;
  assign o_dmem_req   = (state_q == REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[31:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      skip_q      <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      skip_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (chk_ok) begin
              addr_q  <= i_addr;
              f3_q    <= i_funct3;
              we_q    <= i_mem_write;
              wdata_q <= al_wdata;
              wstrb_q <= al_wstrb;
              cnt_q   <= '0;
              state_q <= REQ;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            cnt_q <= '0;
            if (we_q) begin
              done_q  <= 1'b1;
              skip_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end else if (timed_out) begin
            fault_q <= 1'b1;
            skip_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            load_data_q <= al_load;
            done_q      <= 1'b1;
            skip_q      <= 1'b1;
            state_q     <= IDLE;
          end else if (timed_out) begin
            fault_q <= 1'b1;
            skip_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed and random accesses checked
// against a behavioural model of the access rules and latencies.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data;
  logic        o_busy, o_done, o_fault;
  logic [31:0] o_load_data;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_store_data(i_store_data), .o_busy(o_busy), .o_done(o_done),
    .o_load_data(o_load_data), .o_fault(o_fault), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  typedef struct { bit fault; bit is_load; logic [31:0] ld; } rsp_t;
  typedef struct { logic [31:0] addr; bit we; logic [3:0] wstrb; logic [31:0] wdata; } req_t;

  rsp_t exp_q[$];
  req_t req_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Memory responder behaviour for the current access.
  int          m_gnt_dly = 0;
  int          m_rv_dly = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_glitch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int s = acc_size(f3);
    if (s == 0 || f3 == 3'b110) return 0;
    if (we && f3[2]) return 0;
    return (a % s) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int s = acc_size(f3);
    logic [31:0] v, mask;
    if (s == 4) return rdata;
    v = rdata >> (8 * (a % 4));
    mask = (s == 1) ? 32'hFF : 32'hFFFF;
    v = v & mask;
    if (!f3[2] && v > (mask >> 1)) v = v - (mask + 1);
    return v;
  endfunction

  function automatic req_t model_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] sd);
    req_t r;
    int s = acc_size(f3);
    r.addr = a - (a % 4);
    r.we = we;
    r.wstrb = we ? 4'(((1 << s) - 1) << (a % 4)) : 4'b0000;
    if (s == 1) r.wdata = sd[7:0] * 32'h01010101;
    else if (s == 2) r.wdata = sd[15:0] * 32'h00010001;
    else r.wdata = sd;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, holds it while the stage stalls, and checks
  // the number of stall cycles against the model.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input int gd, input int rv,
                        input logic [31:0] rdata, input bit glitch);
    rsp_t r;
    int lat = 0;
    int n = 0;
    bit req_to = 0;
    if (rd ^ wr) begin
      r.is_load = rd;
      r.ld = 32'h0;
      if (!legal(wr, f3, addr)) begin
        r.fault = 1;
      end else begin
        req_q.push_back(model_req(wr, f3, addr, sd));
        if (gd < 0 || gd >= TO) begin
          r.fault = 1; lat = TO + 1; req_to = 1;
        end else if (wr) begin
          r.fault = 0; lat = gd + 2;
        end else if (rv < 0 || rv >= TO) begin
          r.fault = 1; lat = gd + 2 + TO;
        end else begin
          r.fault = 0; lat = gd + rv + 3; r.ld = model_load(f3, addr, rdata);
        end
      end
      exp_q.push_back(r);
    end
    m_gnt_dly = gd; m_rv_dly = rv; m_rdata = rdata; m_glitch = glitch;
    i_valid = 1; i_mem_read = rd; i_mem_write = wr;
    i_funct3 = f3; i_addr = addr; i_store_data = sd;
    forever begin
      @(negedge clk);
      if (!o_busy) break;
      n++;
      if (n > 60) begin
        $display("FAIL stall_bound: busy stuck for %0d cycles", n);
        break;
      end
    end
    check("stall_cycles", n, lat);
    if (req_to) req_q.delete();
    step();
    i_valid = 0;
  endtask

  // Data memory responder.
  initial begin
    int rc = 0;
    int wc = 0;
    bit pend = 0;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 32'h0;
    forever begin
      step();
      i_dmem_gnt = 0;
      i_dmem_rvalid = 0;
      i_dmem_rdata = $urandom;
      if (o_dmem_req) begin
        pend = 0;
        if (rc == m_gnt_dly) begin
          i_dmem_gnt = 1;
          rc = 0;
          if (!o_dmem_we) begin
            pend = 1; wc = 0;
            if (m_glitch) i_dmem_rvalid = 1;
          end
        end else rc++;
      end else begin
        rc = 0;
        if (pend) begin
          if (wc == m_rv_dly) begin
            i_dmem_rvalid = 1; i_dmem_rdata = m_rdata; pend = 0;
          end else wc++;
        end
      end
    end
  end

  // Monitor: checks requests and responses whenever the DUT presents them.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_dmem_req) begin
          if (req_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got addr %h, required no request", o_dmem_addr);
          end else begin
            check("req_addr", o_dmem_addr, req_q[0].addr);
            check("req_we", o_dmem_we, req_q[0].we);
            check("req_wstrb", o_dmem_wstrb, req_q[0].wstrb);
            if (req_q[0].we) check("req_wdata", o_dmem_wdata, req_q[0].wdata);
            if (i_dmem_gnt) void'(req_q.pop_front());
          end
        end
        if (o_done || o_fault) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got done=%b fault=%b, required none", o_done, o_fault);
          end else begin
            e = exp_q.pop_front();
            check("rsp_fault", o_fault, e.fault);
            check("rsp_done", o_done, !e.fault);
            if (e.is_load && !e.fault) check("load_data", o_load_data, e.ld);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, gap;
    logic [2:0] f3;
    i_rst = 1; i_valid = 0; i_mem_read = 0; i_mem_write = 0;
    i_funct3 = 3'b000; i_addr = 32'h0; i_store_data = 32'h0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_fault", o_fault, 0);
    check("rst_req", o_dmem_req, 0);
    check("rst_load_data", o_load_data, 32'h0);
    check("rst_addr", o_dmem_addr, 32'h0);
    check("rst_wstrb", o_dmem_wstrb, 4'h0);
    step();
    i_rst = 0;
    step();

    access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 1);
    access(1, 0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80FF0000, 0);
    access(1, 0, 3'b101, 32'h102, 32'h0, 0, 2, 32'h80FF0000, 0);
    access(0, 1, 3'b000, 32'h205, 32'h12345678, 3, 0, 32'h0, 0);
    access(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0);
    access(0, 1, 3'b001, 32'h301, 32'hABCD, 0, 0, 32'h0, 0);
    access(1, 0, 3'b010, 32'h180, 32'h0, 0, -1, 32'h0, 0);
    access(0, 1, 3'b010, 32'h184, 32'h5555AAAA, -1, 0, 32'h0, 0);
    access(1, 1, 3'b010, 32'h188, 32'h0, 0, 0, 32'h0, 0);

    // Reset while a load waits for rvalid; rvalid then arrives in IDLE.
    m_gnt_dly = 0; m_rv_dly = 3; m_rdata = 32'h13579BDF; m_glitch = 0;
    req_q.push_back(model_req(0, 3'b010, 32'h400, 32'h0));
    i_valid = 1; i_mem_read = 1; i_mem_write = 0; i_funct3 = 3'b010; i_addr = 32'h400;
    step();
    step();
    i_rst = 1; i_valid = 0;
    step();
    i_rst = 0;
    @(negedge clk);
    check("midrst_req", o_dmem_req, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_load_data", o_load_data, 32'h0);
    repeat (4) step();
    check("late_rvalid_load_data", o_load_data, 32'h0);

    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      if (op == 0)
        access(1, 1, f3, $urandom, $urandom, 0, 0, 32'h0, 0);
      else
        access(op >= 5, op < 5, f3, $urandom, $urandom, $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      repeat (gap) step();
    end

    repeat (10) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
